// File: rtl/batch_order_checker.sv
// batch_order_checker
// In-circuit checker that sits beside the batch filter core. It keeps a shadow
// copy of every downsampled input word, indexed by batch slot (0..3) and batch
// index. TAPS independent read taps are compared against that shadow copy, and
// the final result stream is checked for discontinuities. All outputs are
// status and counter registers.
//
// Optional feature macro: BATCH_CHK_FIRST_ERR_EN
//   Adds the first_* capture ports and registers, which record the first tap
//   mismatch seen after reset.
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   in_*         shadow write port (valid, slot, index, sample)
//   tap_*        per-tap read observation (valid, slot, index, sample), packed
//   res_valid    result word valid
//   res          filter output sample (two's complement)
//   err_flag     sticky per-tap mismatch flag
//   err_count    per-tap mismatch counter (packed, CNT_W per tap)
//   miss_count   per-tap count of reads of never-written entries
//   chk_count    total compared tap events
//   disc_count   result discontinuity events
//   first_*      first-error capture (only with BATCH_CHK_FIRST_ERR_EN)
module batch_order_checker #(
  parameter int DEPTH = 32,
  parameter int DSR   = 1,
  parameter int N     = 4,
  parameter int TAPS  = 3,
  parameter int RES_W = 24,
  parameter logic [RES_W-1:0] DISC_THR = 'd300000,
  parameter int CNT_W = 16,
  localparam int L  = DEPTH / DSR,
  localparam int IW = $clog2(L),
  localparam int SW = N * DSR,
  localparam int TW = $clog2(TAPS) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [1:0]              in_cycle,
  input  logic [IW-1:0]           in_idx,
  input  logic [SW-1:0]           in_sample,
  input  logic [TAPS-1:0]         tap_valid,
  input  logic [2*TAPS-1:0]       tap_cycle,
  input  logic [IW*TAPS-1:0]      tap_idx,
  input  logic [SW*TAPS-1:0]      tap_sample,
  input  logic                    res_valid,
  input  logic [RES_W-1:0]        res,
  output logic [TAPS-1:0]         err_flag,
  output logic [CNT_W*TAPS-1:0]   err_count,
  output logic [CNT_W*TAPS-1:0]   miss_count,
  output logic [CNT_W-1:0]        chk_count,
  output logic [CNT_W-1:0]        disc_count
`ifdef BATCH_CHK_FIRST_ERR_EN
  ,
  output logic [TW-1:0]           first_tap,
  output logic [IW-1:0]           first_idx,
  output logic [SW-1:0]           first_exp,
  output logic [SW-1:0]           first_got
`endif
);

  localparam int AW = IW + 2;
  localparam logic [CNT_W-1:0] CMAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CMAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [CNT_W-1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {1'b0, n};
    return s[CNT_W] ? CMAX : s[CNT_W-1:0];
  endfunction

  // One extra bit keeps both the signed difference and its magnitude exact.
  function automatic logic [RES_W:0] abs_diff(input logic signed [RES_W-1:0] a,
                                              input logic signed [RES_W-1:0] b);
    logic signed [RES_W:0] d;
    d = $signed({a[RES_W-1], a}) - $signed({b[RES_W-1], b});
    return d[RES_W] ? (~d + 1'b1) : d;
  endfunction

  // Shadow storage: address is {slot, index}. Only valid bits are reset.
  logic [SW-1:0]   r_mem [4*L];
  logic [4*L-1:0]  r_vld;
  logic [AW-1:0]   w_waddr;
  logic [AW-1:0]   w_raddr [TAPS];

  // Compare pipeline register stage
  logic [TAPS-1:0] r_tv_p1;
  logic [TAPS-1:0] r_hit_p1;
  logic [SW-1:0]   r_exp_p1 [TAPS];
  logic [SW-1:0]   r_got_p1 [TAPS];
  logic [IW-1:0]   r_idx_p1 [TAPS];

  // Counters and status
  logic [CNT_W-1:0] r_err_cnt  [TAPS];
  logic [CNT_W-1:0] r_miss_cnt [TAPS];
  logic [CNT_W-1:0] r_chk_cnt;
  logic [CNT_W-1:0] r_disc_cnt;
  logic [TAPS-1:0]  r_err_flag;
  logic [RES_W-1:0] r_prev_res;
  logic             r_hist_vld;

  logic [TAPS-1:0]  w_cmp;
  logic [TAPS-1:0]  w_miss;
  logic [TAPS-1:0]  w_mis;
  logic [CNT_W-1:0] w_ncmp;
  logic             w_disc;

  assign w_waddr = {in_cycle, in_idx};

  always_comb begin
    for (int t = 0; t < TAPS; t++) begin
      w_raddr[t] = {tap_cycle[2*t +: 2], tap_idx[IW*t +: IW]};
    end
  end

  // Shadow write; the tap read below samples the pre-write content, so a
  // same-cycle write to the same address is not visible to the tap.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_mem[w_waddr] <= in_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else if (in_valid) begin
      r_vld[w_waddr] <= 1'b1;
    end
  end

  // ---- stage p0 -> p1: tap read of the shadow copy ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tv_p1 <= '0;
    end else begin
      r_tv_p1 <= tap_valid;
    end
  end

  always_ff @(posedge clk) begin
    for (int t = 0; t < TAPS; t++) begin
      r_hit_p1[t] <= r_vld[w_raddr[t]];
      r_exp_p1[t] <= r_mem[w_raddr[t]];
      r_got_p1[t] <= tap_sample[SW*t +: SW];
      r_idx_p1[t] <= tap_idx[IW*t +: IW];
    end
  end

  // ---- stage p1 -> counters: compare and account ----
  always_comb begin
    w_ncmp = '0;
    for (int t = 0; t < TAPS; t++) begin
      w_cmp[t]  = r_tv_p1[t] & r_hit_p1[t];
      w_miss[t] = r_tv_p1[t] & ~r_hit_p1[t];
      w_mis[t]  = w_cmp[t] & (r_exp_p1[t] != r_got_p1[t]);
      w_ncmp    = w_ncmp + CNT_W'(w_cmp[t]);
    end
  end

  assign w_disc = res_valid && r_hist_vld &&
                  (abs_diff(res, r_prev_res) > {1'b0, DISC_THR});

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++) begin
        r_err_cnt[t]  <= '0;
        r_miss_cnt[t] <= '0;
      end
      r_err_flag <= '0;
      r_chk_cnt  <= '0;
      r_disc_cnt <= '0;
      r_hist_vld <= 1'b0;
    end else begin
      for (int t = 0; t < TAPS; t++) begin
        if (w_miss[t]) r_miss_cnt[t] <= sat_inc(r_miss_cnt[t]);
        if (w_mis[t]) begin
          r_err_cnt[t]  <= sat_inc(r_err_cnt[t]);
          r_err_flag[t] <= 1'b1;
        end
      end
      r_chk_cnt <= sat_add(r_chk_cnt, w_ncmp);
      if (w_disc) r_disc_cnt <= sat_inc(r_disc_cnt);
      if (res_valid) r_hist_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res_valid) begin
      r_prev_res <= res;
    end
  end

  always_comb begin
    err_count  = '0;
    miss_count = '0;
    for (int t = 0; t < TAPS; t++) begin
      err_count[CNT_W*t +: CNT_W]  = r_err_cnt[t];
      miss_count[CNT_W*t +: CNT_W] = r_miss_cnt[t];
    end
  end

  assign err_flag   = r_err_flag;
  assign chk_count  = r_chk_cnt;
  assign disc_count = r_disc_cnt;

`ifdef BATCH_CHK_FIRST_ERR_EN
  // All-ones tap id means nothing captured yet; a real tap id never reaches
  // all-ones because TW has one spare bit.
  logic [TW-1:0] r_first_tap;
  logic [IW-1:0] r_first_idx;
  logic [SW-1:0] r_first_exp;
  logic [SW-1:0] r_first_got;
  logic [TW-1:0] w_fsel;
  logic [IW-1:0] w_fidx;
  logic [SW-1:0] w_fexp;
  logic [SW-1:0] w_fgot;

  // Scan downward so the lowest mismatching tap id wins.
  always_comb begin
    w_fsel = '0;
    w_fidx = '0;
    w_fexp = '0;
    w_fgot = '0;
    for (int t = TAPS - 1; t >= 0; t--) begin
      if (w_mis[t]) begin
        w_fsel = TW'(t);
        w_fidx = r_idx_p1[t];
        w_fexp = r_exp_p1[t];
        w_fgot = r_got_p1[t];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_first_tap <= '1;
      r_first_idx <= '0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else if ((r_first_tap == '1) && (|w_mis)) begin
      r_first_tap <= w_fsel;
      r_first_idx <= w_fidx;
      r_first_exp <= w_fexp;
      r_first_got <= w_fgot;
    end
  end

  assign first_tap = r_first_tap;
  assign first_idx = r_first_idx;
  assign first_exp = r_first_exp;
  assign first_got = r_first_got;
`endif

endmodule

// File: tb/tb_batch_order_checker.sv
// Scoreboard bench for batch_order_checker: stimulus pushes expected register
// values tagged with the cycle they must hold in; a monitor pops and compares
// them on the falling edge. A second instance with 4-bit counters shares the
// same inputs to exercise saturation.
module tb_batch_order_checker;

  localparam int TAPS = 3;
  localparam int IW   = 5;
  localparam int SW   = 8;
  localparam int CW   = 16;
  localparam int SCW  = 4;
  localparam int TW   = 3;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [1:0] in_cycle;
  logic [IW-1:0] in_idx;
  logic [SW-1:0] in_sample;
  logic [TAPS-1:0] tap_valid;
  logic [2*TAPS-1:0] tap_cycle;
  logic [IW*TAPS-1:0] tap_idx;
  logic [SW*TAPS-1:0] tap_sample;
  logic res_valid;
  logic [23:0] res;

  logic [TAPS-1:0] err_flag, s_err_flag;
  logic [CW*TAPS-1:0] err_count, miss_count;
  logic [SCW*TAPS-1:0] s_err_count, s_miss_count;
  logic [CW-1:0] chk_count, disc_count;
  logic [SCW-1:0] s_chk_count, s_disc_count;
`ifdef BATCH_CHK_FIRST_ERR_EN
  logic [TW-1:0] first_tap, s_first_tap;
  logic [IW-1:0] first_idx, s_first_idx;
  logic [SW-1:0] first_exp, first_got, s_first_exp, s_first_got;
`endif

  always #5 clk = ~clk;

  batch_order_checker #(.DEPTH(32), .DSR(1), .N(8), .TAPS(TAPS), .RES_W(24),
                        .DISC_THR(24'd300000), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_cycle(in_cycle),
    .in_idx(in_idx), .in_sample(in_sample), .tap_valid(tap_valid),
    .tap_cycle(tap_cycle), .tap_idx(tap_idx), .tap_sample(tap_sample),
    .res_valid(res_valid), .res(res), .err_flag(err_flag),
    .err_count(err_count), .miss_count(miss_count), .chk_count(chk_count),
    .disc_count(disc_count)
`ifdef BATCH_CHK_FIRST_ERR_EN
    , .first_tap(first_tap), .first_idx(first_idx),
    .first_exp(first_exp), .first_got(first_got)
`endif
  );

  batch_order_checker #(.DEPTH(32), .DSR(1), .N(8), .TAPS(TAPS), .RES_W(24),
                        .DISC_THR(24'd300000), .CNT_W(SCW)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_cycle(in_cycle),
    .in_idx(in_idx), .in_sample(in_sample), .tap_valid(tap_valid),
    .tap_cycle(tap_cycle), .tap_idx(tap_idx), .tap_sample(tap_sample),
    .res_valid(res_valid), .res(res), .err_flag(s_err_flag),
    .err_count(s_err_count), .miss_count(s_miss_count), .chk_count(s_chk_count),
    .disc_count(s_disc_count)
`ifdef BATCH_CHK_FIRST_ERR_EN
    , .first_tap(s_first_tap), .first_idx(s_first_idx),
    .first_exp(s_first_exp), .first_got(s_first_got)
`endif
  );

  // Selector codes for the observed register
  localparam int S_FLAG = 0, S_ERR0 = 1, S_ERR1 = 2, S_ERR2 = 3;
  localparam int S_MISS0 = 4, S_MISS1 = 5, S_MISS2 = 6, S_CHK = 7, S_DISC = 8;
  localparam int S_SERR0 = 9, S_SCHK = 10, S_FTAP = 11, S_FIDX = 12;
  localparam int S_FEXP = 13, S_FGOT = 14;

  string names [15] = '{"err_flag", "err_count0", "err_count1", "err_count2",
                        "miss_count0", "miss_count1", "miss_count2", "chk_count",
                        "disc_count", "sat_err_count0", "sat_chk_count",
                        "first_tap", "first_idx", "first_exp", "first_got"};

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb [$];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_FLAG:  return 32'(err_flag);
      S_ERR0:  return 32'(err_count[0*CW +: CW]);
      S_ERR1:  return 32'(err_count[1*CW +: CW]);
      S_ERR2:  return 32'(err_count[2*CW +: CW]);
      S_MISS0: return 32'(miss_count[0*CW +: CW]);
      S_MISS1: return 32'(miss_count[1*CW +: CW]);
      S_MISS2: return 32'(miss_count[2*CW +: CW]);
      S_CHK:   return 32'(chk_count);
      S_DISC:  return 32'(disc_count);
      S_SERR0: return 32'(s_err_count[0 +: SCW]);
      S_SCHK:  return 32'(s_chk_count);
`ifdef BATCH_CHK_FIRST_ERR_EN
      S_FTAP:  return 32'(first_tap);
      S_FIDX:  return 32'(first_idx);
      S_FEXP:  return 32'(first_exp);
      S_FGOT:  return 32'(first_got);
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation whose cycle has arrived.
  exp_t        m_x;
  logic [31:0] m_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_x   = sb.pop_front();
      m_act = actual(m_x.sel);
      n_vec++;
      if (m_act !== m_x.exp) begin
        n_err++;
        $display("FAIL %s @cyc %0d: got 'h%0h, expected 'h%0h",
                 names[m_x.sel], cyc, m_act, m_x.exp);
      end
    end
  end

  task automatic expect_at(input int sel, input logic [31:0] e, input int d);
    exp_t x;
    x.cyc = cyc + d;
    x.sel = sel;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    tap_valid = '0;
    res_valid = 1'b0;
  endtask

  task automatic set_wr(input logic [1:0] c, input logic [4:0] i, input logic [7:0] s);
    in_valid  = 1'b1;
    in_cycle  = c;
    in_idx    = i;
    in_sample = s;
  endtask

  task automatic set_tap(input int t, input logic [1:0] c, input logic [4:0] i,
                         input logic [7:0] s);
    tap_valid[t]          = 1'b1;
    tap_cycle[2*t +: 2]   = c;
    tap_idx[IW*t +: IW]   = i;
    tap_sample[SW*t +: SW] = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic res_step(input logic [23:0] v);
    res_valid = 1'b1;
    res       = v;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_cycle = '0; in_idx = '0; in_sample = '0;
    tap_cycle = '0; tap_idx = '0; tap_sample = '0; res = '0;
    idle_inputs();
    tick();
    tick();
    // Reset state
    expect_at(S_FLAG, 0, 0);
    expect_at(S_ERR0, 0, 0);
    expect_at(S_MISS0, 0, 0);
    expect_at(S_CHK, 0, 0);
    expect_at(S_DISC, 0, 0);
`ifdef BATCH_CHK_FIRST_ERR_EN
    expect_at(S_FTAP, 32'h7, 0);
`endif
    rst = 1'b0;

    // Shadow round-trip: slot 0 idx 0..31 = idx, tap0 reads back in reverse
    for (int i = 0; i < 32; i++) begin
      set_wr(2'd0, 5'(i), 8'(i));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      set_tap(0, 2'd0, 5'(i), 8'(i));
      tick();
    end
    tap_valid = '0;
    tick();
    expect_at(S_CHK, 32, 0);
    expect_at(S_ERR0, 0, 0);
    expect_at(S_MISS0, 0, 0);
    expect_at(S_FLAG, 0, 0);
    n_vec++;
    if (chk_count !== 16'd32) begin
      n_err++;
      $display("FAIL round-trip chk_count: got %0d, expected 32", chk_count);
    end
    n_vec++;
    if (err_count[0 +: CW] !== 16'd0) begin
      n_err++;
      $display("FAIL round-trip err_count0: got %0d, expected 0", err_count[0 +: CW]);
    end
    n_vec++;
    if (miss_count[0 +: CW] !== 16'd0) begin
      n_err++;
      $display("FAIL round-trip miss_count0: got %0d, expected 0", miss_count[0 +: CW]);
    end

    // Injected mismatch on tap1
    set_wr(2'd2, 5'd5, 8'hA5);
    tick();
    in_valid = 1'b0;
    set_tap(1, 2'd2, 5'd5, 8'hA4);
    tick();
    tap_valid = '0;
    expect_at(S_FLAG, 0, 0);
    expect_at(S_FLAG, 3'b010, 1);
    expect_at(S_ERR1, 1, 1);
    expect_at(S_CHK, 33, 1);
`ifdef BATCH_CHK_FIRST_ERR_EN
    expect_at(S_FTAP, 1, 1);
    expect_at(S_FIDX, 5, 1);
    expect_at(S_FEXP, 8'hA5, 1);
    expect_at(S_FGOT, 8'hA4, 1);
`endif
    tick();

    // Unwritten read, then same-cycle write/read collision
    do_reset();
    expect_at(S_CHK, 0, 0);
    expect_at(S_ERR1, 0, 0);
    expect_at(S_FLAG, 0, 0);
`ifdef BATCH_CHK_FIRST_ERR_EN
    expect_at(S_FTAP, 32'h7, 0);
`endif
    set_tap(2, 2'd3, 5'd7, 8'h00);
    tick();
    tap_valid = '0;
    expect_at(S_MISS2, 1, 1);
    expect_at(S_CHK, 0, 1);
    set_wr(2'd3, 5'd7, 8'h3C);
    set_tap(2, 2'd3, 5'd7, 8'h3C);
    tick();
    idle_inputs();
    expect_at(S_MISS2, 2, 1);
    expect_at(S_FLAG, 0, 1);
    expect_at(S_CHK, 0, 1);
    set_tap(2, 2'd3, 5'd7, 8'h3C);
    tick();
    tap_valid = '0;
    expect_at(S_CHK, 1, 1);
    expect_at(S_MISS2, 2, 1);
    expect_at(S_FLAG, 0, 1);
    // Three taps at once: tap0 and tap1 mismatch, tap2 hits an unwritten entry
    set_tap(0, 2'd3, 5'd7, 8'h3E);
    set_tap(1, 2'd3, 5'd7, 8'h3D);
    set_tap(2, 2'd1, 5'd0, 8'h00);
    tick();
    tap_valid = '0;
    expect_at(S_CHK, 3, 1);
    expect_at(S_FLAG, 3'b011, 1);
    expect_at(S_ERR0, 1, 1);
    expect_at(S_ERR1, 1, 1);
    expect_at(S_MISS2, 3, 1);
`ifdef BATCH_CHK_FIRST_ERR_EN
    expect_at(S_FTAP, 0, 1);
    expect_at(S_FIDX, 7, 1);
    expect_at(S_FEXP, 8'h3C, 1);
    expect_at(S_FGOT, 8'h3E, 1);
`endif
    tick();

    // Continuity: 0, 300000, 600001, 600001, -300000, 0
    res_step(24'd0);
    expect_at(S_DISC, 0, 0);
    res_step(24'd300000);
    expect_at(S_DISC, 0, 0);
    res_step(24'd600001);
    expect_at(S_DISC, 1, 0);
    n_vec++;
    if (disc_count !== 16'd1) begin
      n_err++;
      $display("FAIL continuity disc_count: got %0d, expected 1", disc_count);
    end
    tick();
    res_step(24'd600001);
    expect_at(S_DISC, 1, 0);
    res_step(24'(-300000));
    expect_at(S_DISC, 2, 0);
    res_step(24'd0);
    expect_at(S_DISC, 2, 0);

    // Saturation: 20 mismatches on tap0 (slot 3 idx 7 holds 3C)
    for (int i = 0; i < 20; i++) begin
      set_tap(0, 2'd3, 5'd7, 8'h00);
      tick();
    end
    tap_valid = '0;
    expect_at(S_SERR0, 15, 1);
    expect_at(S_SCHK, 15, 1);
    expect_at(S_ERR0, 21, 1);
    expect_at(S_CHK, 23, 1);
    tick();
    tick();
    tick();
    expect_at(S_SERR0, 15, 0);
    n_vec++;
    if (s_err_count[0 +: SCW] !== 4'd15) begin
      n_err++;
      $display("FAIL saturation err_count0: got %0d, expected 15", s_err_count[0 +: SCW]);
    end

    // Mid-batch reset after 3 errors
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_wr(2'd1, 5'(i), 8'(8'h10 + i));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_tap(1, 2'd1, 5'(i), 8'hFF);
      tick();
    end
    tap_valid = '0;
    tick();
    expect_at(S_ERR1, 3, 0);
    expect_at(S_FLAG, 3'b010, 0);
    // Reset with a write, a tap and a result all active in the same cycle
    set_wr(2'd1, 5'd3, 8'h99);
    set_tap(0, 2'd1, 5'd0, 8'h00);
    res_valid = 1'b1;
    res       = 24'd0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    expect_at(S_FLAG, 0, 0);
    expect_at(S_ERR1, 0, 0);
    expect_at(S_CHK, 0, 0);
    expect_at(S_MISS2, 0, 0);
    expect_at(S_DISC, 0, 0);
    n_vec++;
    if (err_flag !== 3'b000) begin
      n_err++;
      $display("FAIL mid-batch reset err_flag: got %b, expected 000", err_flag);
    end
    n_vec++;
    if (err_count[1*CW +: CW] !== 16'd0) begin
      n_err++;
      $display("FAIL mid-batch reset err_count1: got %0d, expected 0", err_count[1*CW +: CW]);
    end
    expect_at(S_FLAG, 0, 1);
    expect_at(S_ERR0, 0, 1);
    set_tap(0, 2'd1, 5'd0, 8'h10);
    tick();
    tap_valid = '0;
    expect_at(S_MISS0, 1, 1);
    expect_at(S_CHK, 0, 1);
    set_tap(0, 2'd1, 5'd3, 8'h99);
    tick();
    tap_valid = '0;
    expect_at(S_MISS0, 2, 1);
    expect_at(S_ERR0, 0, 1);
    res_step(24'd8000000);
    expect_at(S_DISC, 0, 0);
    res_step(24'd0);
    expect_at(S_DISC, 1, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      m_x = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: expectation for cyc %0d never compared (timeout)",
               names[m_x.sel], m_x.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
